dual_ram_bw: RTL and testbench

- Parametrised simple dual-port synchronous RAM: one write port and one read port on a single clock.
- Adds per-lane write enables, a selectable read latency, and a defined read-during-write mode.
- Adds a hardware clear sequencer that zeroes the whole array after every reset, so the array can map to block RAM.
- Drop-in storage element for buffers and FIFOs; consumers wait for init_busy low before issuing traffic.

---
 rtl/dual_ram_pkg.sv | 17 +
 rtl/dual_ram_bw_if.sv | 35 +++
 rtl/dual_ram_init_ctrl.sv | 56 +++++
 rtl/dual_ram_bw.sv | 118 +++++++++++
 tb/tb_dual_ram_bw.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dual_ram_pkg.sv
// Shared types and helpers for the dual_ram_bw storage block.
// Clear-sequencer state encoding, read-during-write mode values and lane count.
package dual_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int num_lanes(input int width, input int byte_w);
        return width / byte_w;
    endfunction

endpackage

// File: rtl/dual_ram_bw_if.sv
// Write/read port bundle of dual_ram_bw; the master issues traffic, the RAM is the slave.
interface dual_ram_bw_if
    import dual_ram_pkg::*;
#(
    parameter int RAM_WIDTH = 32,
    parameter int ADDR_SIZE = 8,
    parameter int BYTE_W    = 8
);
    localparam int NUM_LANES = num_lanes(RAM_WIDTH, BYTE_W);

    // Handshake: there is no ready signal and no backpressure. A request is taken on every
    // rising edge where its enable is high and init_busy is low; each taken read returns
    // exactly one single-cycle rd_valid pulse, in request order, with data_out and rd_collision.
    logic                 wr_enb;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [NUM_LANES-1:0] wr_be;
    logic [RAM_WIDTH-1:0] data_in;
    logic                 rd_enb;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [RAM_WIDTH-1:0] data_out;
    logic                 rd_valid;
    logic                 rd_collision;
    logic                 init_busy;

    modport master (
        output wr_enb, wr_addr, wr_be, data_in, rd_enb, rd_addr,
        input  data_out, rd_valid, rd_collision, init_busy
    );

    modport slave (
        input  wr_enb, wr_addr, wr_be, data_in, rd_enb, rd_addr,
        output data_out, rd_valid, rd_collision, init_busy
    );

endinterface

// File: rtl/dual_ram_init_ctrl.sv
// Clear sequencer: after every reset, sweeps the array writing zero, one word per cycle.
// Restarts from address 0 whenever reset is asserted, even mid-sweep.
module dual_ram_init_ctrl
    import dual_ram_pkg::*;
#(
    parameter int RAM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 clr_we_o,
    output logic [ADDR_SIZE-1:0] clr_addr_o,
    output logic                 init_busy_o,
    output state_t               state_o
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_DEPTH - 1);

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The last zero write and the move to READY share one edge, so the sweep is RAM_DEPTH cycles.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_we_o = 1'b0;
        case (state_q)
            INIT: begin
                clr_we_o = 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    assign clr_addr_o  = ptr_q;
    assign init_busy_o = (state_q == INIT);
    assign state_o     = state_q;

endmodule

// File: rtl/dual_ram_bw.sv
// Simple dual-port RAM with lane write enables, 1- or 2-cycle reads, defined
// read-during-write behaviour and a post-reset clear sweep.
module dual_ram_bw
    import dual_ram_pkg::*;
#(
    parameter int RAM_WIDTH  = 32,
    parameter int RAM_DEPTH  = 256,
    parameter int ADDR_SIZE  = 8,
    parameter int BYTE_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input logic         clk,
    input logic         rst,
    dual_ram_bw_if.slave bus
);

    localparam int                   NUM_LANES = num_lanes(RAM_WIDTH, BYTE_W);
    localparam logic [ADDR_SIZE:0]   DEPTH_W   = (ADDR_SIZE + 1)'(RAM_DEPTH);

    if ((RAM_WIDTH % BYTE_W) != 0) begin : g_bad_width
        $error("dual_ram_bw: RAM_WIDTH must be a multiple of BYTE_W");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("dual_ram_bw: RD_LATENCY must be 1 or 2");
    end
    if (RAM_DEPTH < 2 || RAM_DEPTH > (1 << ADDR_SIZE)) begin : g_bad_depth
        $error("dual_ram_bw: RAM_DEPTH out of range for ADDR_SIZE");
    end

    state_t               state;
    logic                 clr_we;
    logic [ADDR_SIZE-1:0] clr_addr;
    logic                 init_busy;

    dual_ram_init_ctrl #(
        .RAM_DEPTH (RAM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_init (
        .clk         (clk),
        .rst         (rst),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .init_busy_o (init_busy),
        .state_o     (state)
    );

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    logic                 ready;
    logic                 wr_in_range, rd_in_range;
    logic                 wr_acc, rd_acc, collide;
    logic [RAM_WIDTH-1:0] old_word, rd_word;

    assign ready       = (state == READY);
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);
    assign wr_acc      = ready && bus.wr_enb && wr_in_range;
    assign rd_acc      = ready && bus.rd_enb;
    assign collide     = rd_acc && bus.wr_enb && (bus.rd_addr == bus.wr_addr) && (|bus.wr_be);
    assign old_word    = rd_in_range ? mem[bus.rd_addr] : '0;

    // New-data mode forwards the enabled lanes of the colliding write over the stored word.
    always_comb begin
        rd_word = old_word;
        if (RDW_MODE == RDW_NEW && collide && wr_in_range) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (bus.wr_be[l]) begin
                    rd_word[l*BYTE_W +: BYTE_W] = bus.data_in[l*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Array has no reset so it can map to block RAM; the clear sweep owns the port during INIT.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (bus.wr_be[l]) begin
                    mem[bus.wr_addr][l*BYTE_W +: BYTE_W] <= bus.data_in[l*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    logic                 p1_valid_q, p1_coll_q, p2_valid_q, p2_coll_q;
    logic [RAM_WIDTH-1:0] p1_data_q, p2_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid_q <= 1'b0;
            p1_coll_q  <= 1'b0;
            p1_data_q  <= '0;
            p2_valid_q <= 1'b0;
            p2_coll_q  <= 1'b0;
            p2_data_q  <= '0;
        end else begin
            p1_valid_q <= rd_acc;
            p1_coll_q  <= collide;
            if (rd_acc) begin
                p1_data_q <= rd_word;
            end
            p2_valid_q <= p1_valid_q;
            p2_coll_q  <= p1_coll_q;
            if (p1_valid_q) begin
                p2_data_q <= p1_data_q;
            end
        end
    end

    assign bus.data_out     = (RD_LATENCY == 2) ? p2_data_q  : p1_data_q;
    assign bus.rd_valid     = (RD_LATENCY == 2) ? p2_valid_q : p1_valid_q;
    assign bus.rd_collision = (RD_LATENCY == 2) ? p2_coll_q  : p1_coll_q;
    assign bus.init_busy    = init_busy;

endmodule

// File: tb/tb_dual_ram_bw.sv
// Directed bench for dual_ram_bw: instance A uses the defaults (depth 256, latency 1, old-data),
// instance B uses depth 200, latency 2 and new-data forwarding.
module tb_dual_ram_bw;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dual_ram_bw_if #(.RAM_WIDTH(32), .ADDR_SIZE(8), .BYTE_W(8)) a_if ();
    dual_ram_bw_if #(.RAM_WIDTH(32), .ADDR_SIZE(8), .BYTE_W(8)) b_if ();

    dual_ram_bw #(
        .RAM_WIDTH(32), .RAM_DEPTH(256), .ADDR_SIZE(8), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    dual_ram_bw #(
        .RAM_WIDTH(32), .RAM_DEPTH(200), .ADDR_SIZE(8), .BYTE_W(8), .RD_LATENCY(2), .RDW_MODE(1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
        a_if.wr_enb = 1'b1; a_if.wr_addr = addr; a_if.wr_be = be; a_if.data_in = d;
        tick();
        a_if.wr_enb = 1'b0;
    endtask

    task automatic write_b(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
        b_if.wr_enb = 1'b1; b_if.wr_addr = addr; b_if.wr_be = be; b_if.data_in = d;
        tick();
        b_if.wr_enb = 1'b0;
    endtask

    task automatic read_a(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        a_if.rd_enb = 1'b1; a_if.rd_addr = addr;
        tick();
        a_if.rd_enb = 1'b0;
        check_eq({tag, "_valid"}, 32'(a_if.rd_valid), 32'd1);
        check_eq({tag, "_data"}, a_if.data_out, exp);
    endtask

    task automatic read_b(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        b_if.rd_enb = 1'b1; b_if.rd_addr = addr;
        tick();
        b_if.rd_enb = 1'b0;
        check_eq({tag, "_early"}, 32'(b_if.rd_valid), 32'd0);
        tick();
        check_eq({tag, "_valid"}, 32'(b_if.rd_valid), 32'd1);
        check_eq({tag, "_data"}, b_if.data_out, exp);
    endtask

    // Reads are requested throughout the sweep; none may be accepted while init_busy is high.
    task automatic count_init(output int na, output int nb, output int nv);
        na = 0; nb = 0; nv = 0;
        for (int i = 0; i < 300; i++) begin
            if (a_if.init_busy) na++;
            if (b_if.init_busy) nb++;
            if (a_if.rd_valid || b_if.rd_valid) nv++;
            a_if.rd_enb = a_if.init_busy; a_if.rd_addr = 8'h00;
            b_if.rd_enb = b_if.init_busy; b_if.rd_addr = 8'h00;
            tick();
        end
        a_if.rd_enb = 1'b0;
        b_if.rd_enb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, nv, first, last, got;

        a_if.wr_enb = 0; a_if.wr_addr = 0; a_if.wr_be = 0; a_if.data_in = 0;
        a_if.rd_enb = 0; a_if.rd_addr = 0;
        b_if.wr_enb = 0; b_if.wr_addr = 0; b_if.wr_be = 0; b_if.data_in = 0;
        b_if.rd_enb = 0; b_if.rd_addr = 0;
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_a_busy", 32'(a_if.init_busy), 32'd1);
        check_eq("rst_a_data", a_if.data_out, 32'h0);
        check_eq("rst_a_valid", 32'(a_if.rd_valid), 32'd0);
        check_eq("rst_a_coll", 32'(a_if.rd_collision), 32'd0);
        check_eq("rst_b_busy", 32'(b_if.init_busy), 32'd1);

        rst = 1'b0;
        count_init(na, nb, nv);
        check_eq("init_a_cycles", 32'(na), 32'd256);
        check_eq("init_b_cycles", 32'(nb), 32'd200);
        check_eq("init_no_valid", 32'(nv), 32'd0);
        check_eq("init_a_done", 32'(a_if.init_busy), 32'd0);

        read_a("clr_00", 8'h00, 32'h0);
        read_a("clr_7f", 8'h7F, 32'h0);
        read_a("clr_ff", 8'hFF, 32'h0);

        write_a(8'd5, 32'hAABBCCDD, 4'hF);
        write_a(8'd5, 32'h11223344, 4'b0101);
        read_a("lane_merge", 8'd5, 32'hAA22CC44);
        tick();
        check_eq("a_pulse_end", 32'(a_if.rd_valid), 32'd0);
        check_eq("a_data_hold", a_if.data_out, 32'hAA22CC44);

        // Same-address read and write, old-data mode.
        a_if.wr_enb = 1; a_if.wr_addr = 8'd9; a_if.wr_be = 4'hF; a_if.data_in = 32'hDEADBEEF;
        a_if.rd_enb = 1; a_if.rd_addr = 8'd9;
        tick();
        a_if.wr_enb = 0; a_if.rd_enb = 0;
        check_eq("a_coll_valid", 32'(a_if.rd_valid), 32'd1);
        check_eq("a_coll_data", a_if.data_out, 32'h0);
        check_eq("a_coll_flag", 32'(a_if.rd_collision), 32'd1);
        read_a("a_after_coll", 8'd9, 32'hDEADBEEF);
        check_eq("a_after_coll_flag", 32'(a_if.rd_collision), 32'd0);

        a_if.wr_enb = 1; a_if.wr_addr = 8'd10; a_if.wr_be = 4'hF; a_if.data_in = 32'h12345678;
        a_if.rd_enb = 1; a_if.rd_addr = 8'd5;
        tick();
        a_if.wr_enb = 0; a_if.rd_enb = 0;
        check_eq("a_indep_data", a_if.data_out, 32'hAA22CC44);
        check_eq("a_indep_flag", 32'(a_if.rd_collision), 32'd0);
        write_a(8'd10, 32'hFFFFFFFF, 4'h0);
        read_a("a_be0_noop", 8'd10, 32'h12345678);

        // Latency-2 streaming, checked against an expected queue.
        write_b(8'd1, 32'h00000101, 4'hF);
        write_b(8'd2, 32'h00000202, 4'hF);
        write_b(8'd3, 32'h00000303, 4'hF);
        exp_q.push_back(32'h00000101);
        exp_q.push_back(32'h00000202);
        exp_q.push_back(32'h00000303);
        first = -1; last = -1; got = 0;
        for (int i = 0; i < 6; i++) begin
            b_if.rd_enb  = (i < 3);
            b_if.rd_addr = 8'(i + 1);
            tick();
            if (b_if.rd_valid) begin
                if (first < 0) first = i;
                last = i;
                got++;
                if (exp_q.size() > 0) check_eq("b_stream_data", b_if.data_out, exp_q.pop_front());
                else check_eq("b_stream_extra", 32'd1, 32'd0);
            end
        end
        b_if.rd_enb = 0;
        check_eq("b_stream_count", 32'(got), 32'd3);
        check_eq("b_stream_first", 32'(first), 32'd1);
        check_eq("b_stream_last", 32'(last), 32'd3);
        check_eq("b_stream_hold", b_if.data_out, 32'h00000303);

        // Same-address read and write, new-data mode with two lanes enabled.
        b_if.wr_enb = 1; b_if.wr_addr = 8'd9; b_if.wr_be = 4'b0011; b_if.data_in = 32'hDEADBEEF;
        b_if.rd_enb = 1; b_if.rd_addr = 8'd9;
        tick();
        b_if.wr_enb = 0; b_if.rd_enb = 0;
        check_eq("b_coll_early", 32'(b_if.rd_valid), 32'd0);
        tick();
        check_eq("b_coll_valid", 32'(b_if.rd_valid), 32'd1);
        check_eq("b_coll_data", b_if.data_out, 32'h0000BEEF);
        check_eq("b_coll_flag", 32'(b_if.rd_collision), 32'd1);
        read_b("b_after_coll", 8'd9, 32'h0000BEEF);

        write_b(8'd210, 32'hFFFFFFFF, 4'hF);
        read_b("b_oor_210", 8'd210, 32'h0);
        read_b("b_oor_199", 8'd199, 32'h0);
        read_b("b_oor_82", 8'd82, 32'h0);
        read_b("b_oor_10", 8'd10, 32'h0);

        // Reset with reads in flight on both instances.
        a_if.rd_enb = 1; a_if.rd_addr = 8'd5;
        b_if.rd_enb = 1; b_if.rd_addr = 8'd1;
        tick();
        a_if.rd_enb = 0; b_if.rd_enb = 0;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_a_valid", 32'(a_if.rd_valid), 32'd0);
        check_eq("mid_rst_a_data", a_if.data_out, 32'h0);
        check_eq("mid_rst_a_busy", 32'(a_if.init_busy), 32'd1);
        tick();
        check_eq("mid_rst_b_valid", 32'(b_if.rd_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check_eq("clr100_a_busy", 32'(a_if.init_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_init(na, nb, nv);
        check_eq("reinit_a_cycles", 32'(na), 32'd256);
        check_eq("reinit_b_cycles", 32'(nb), 32'd200);
        check_eq("reinit_no_valid", 32'(nv), 32'd0);
        read_a("a_wiped", 8'd5, 32'h0);
        read_a("a_wiped9", 8'd9, 32'h0);
        read_b("b_wiped", 8'd1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
